// File: rtl/uart_fifo_tx_pkg.sv
// Shared UART definitions: transmitter/receiver state encodings, frame config and timing defaults.
package uart_fifo_tx_pkg;

  localparam int unsigned UART_BAUD_DIV = 16;
  localparam int unsigned UART_CNT_W    = 4;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    WAIT1,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef struct packed {
    logic bit8;
    logic parity_en;
    logic odd_n_even;
  } frame_cfg_t;

endpackage

// File: rtl/uart_fifo_tx_if.sv
// TX FIFO read port: the transmitter is the master and pops bytes with an active-low strobe.
interface uart_fifo_tx_if;
  logic       fifo_empty;
  logic       fifo_rd_n;
  logic [7:0] fifo_data;

  modport master (input fifo_empty, input fifo_data, output fifo_rd_n);
  modport slave  (output fifo_empty, output fifo_data, input fifo_rd_n);
endinterface

// File: rtl/uart_fifo_tx.sv
// UART transmitter fed from a TX FIFO: pops a byte, frames it (start, 7/8 data, optional parity, stop)
// and shifts it out LSB first, one bit per BAUD_DIV baud_en pulses.
module uart_fifo_tx
  import uart_fifo_tx_pkg::*;
#(
  parameter int unsigned BAUD_DIV = UART_BAUD_DIV
) (
  input  logic           clock,
  input  logic           aresetn,
  input  logic           baud_en,
  uart_fifo_tx_if.master fifo,
  input  logic           bit8,
  input  logic           parity_en,
  input  logic           odd_n_even,
  output logic           tx,
  output logic           tx_busy,
  output logic           tx_done
);

  tx_state_e             state, state_nx;
  logic [UART_CNT_W-1:0] baud_cnt;
  logic [2:0]            bit_idx;
  logic [7:0]            shreg;
  frame_cfg_t            cfg;
  logic                  par_x;
  logic                  arm_q;
  logic                  tx_q;
  logic                  done_q;
  logic                  rd_n;
  logic                  in_frame;
  logic                  bit_end;
  logic                  last_data;

  assign in_frame  = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
  assign bit_end   = in_frame && baud_en && (baud_cnt == UART_CNT_W'(BAUD_DIV - 1));
  assign last_data = (bit_idx == (cfg.bit8 ? 3'd7 : 3'd6));

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nx;
  end

  // arm_q holds off the first pop until the second edge after reset release
  always_comb begin
    state_nx = state;
    rd_n     = 1'b1;
    case (state)
      IDLE:    if (arm_q && !fifo.fifo_empty) state_nx = POP;
      POP: begin
        rd_n     = 1'b0;
        state_nx = WAIT1;
      end
      WAIT1:   state_nx = LOAD;
      LOAD:    state_nx = START;
      START:   if (bit_end) state_nx = DATA;
      DATA:    if (bit_end && last_data) state_nx = cfg.parity_en ? PARITY : STOP;
      PARITY:  if (bit_end) state_nx = STOP;
      STOP:    if (bit_end) state_nx = fifo.fifo_empty ? IDLE : POP;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      cfg      <= '0;
      par_x    <= 1'b0;
      arm_q    <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      arm_q  <= 1'b1;
      done_q <= (state == STOP) && bit_end;

      if (state == LOAD)          baud_cnt <= '0;
      else if (in_frame && baud_en) baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;

      // tx is updated on the same edge as the state, so the line always matches the current bit
      if (state == LOAD) begin
        shreg   <= fifo.fifo_data;
        cfg     <= '{bit8: bit8, parity_en: parity_en, odd_n_even: odd_n_even};
        par_x   <= ^(fifo.fifo_data & {bit8, 7'h7F});
        bit_idx <= '0;
        tx_q    <= 1'b0;
      end else if (bit_end) begin
        case (state)
          START: begin
            tx_q  <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
          end
          DATA: begin
            if (last_data) begin
              tx_q <= cfg.parity_en ? (par_x ^ cfg.odd_n_even) : 1'b1;
            end else begin
              tx_q    <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end
          PARITY:  tx_q <= 1'b1;
          default: tx_q <= 1'b1;
        endcase
      end
    end
  end

  assign fifo.fifo_rd_n = rd_n;
  assign tx             = tx_q;
  assign tx_done        = done_q;
  assign tx_busy        = (state != IDLE);

endmodule

// File: doc/uart_fifo_tx.md
UART_FIFO_TX -- requirements
Module: uart_fifo_tx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 16, meaning number of baud_en pulses per serial bit (range 2..16).
REQ-002 SHALL have port clock, input, 1, system clock; all logic on its rising edge.
REQ-003 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port baud_en, input, 1, single-cycle oversample enable pulse.
REQ-005 SHALL have port fifo_empty, input, 1, TX FIFO empty flag.
REQ-006 SHALL have port fifo_rd_n, output, 1, TX FIFO read strobe, active low, one clock per pop.
REQ-007 SHALL have port fifo_data, input, 8, TX FIFO output byte; valid in the second clock after the fifo_rd_n-low clock.
REQ-008 SHALL have port bit8, input, 1, 1 = 8 data bits, 0 = 7 data bits.
REQ-009 SHALL have port parity_en, input, 1, parity bit enable.
REQ-010 SHALL have port odd_n_even, input, 1, 1 = odd parity, 0 = even parity.
REQ-011 SHALL have port tx, output, 1, serial line, idle high.
REQ-012 SHALL have port tx_busy, output, 1, high in every state except IDLE.
REQ-013 SHALL have port tx_done, output, 1, one-clock pulse at the end of each stop bit.

Function
REQ-014 SHALL implement FSM states IDLE, POP, WAIT1, LOAD, START, DATA, PARITY, STOP.
REQ-015 IDLE SHALL go to POP when fifo_empty=0; otherwise it SHALL remain in IDLE.
REQ-016 POP SHALL drive fifo_rd_n=0 for exactly one clock, then go to WAIT1.
REQ-017 fifo_rd_n SHALL be 1 in every state except POP, and POP SHALL only be entered when fifo_empty=0.
REQ-018 WAIT1 SHALL last one clock, then go to LOAD.
REQ-019 LOAD SHALL capture fifo_data into the shift register.
REQ-020 LOAD SHALL capture bit8, parity_en and odd_n_even into frame config registers; changes to these inputs mid-frame SHALL have no effect.
REQ-021 LOAD SHALL clear the bit-time counter, then go to START.
REQ-022 Bit timing: the bit-time counter SHALL increment on each baud_en; a bit ends on the baud_en at which the counter equals BAUD_DIV-1, and the counter then returns to 0.
REQ-023 START SHALL drive tx=0 for one bit time.
REQ-024 DATA SHALL send the data bits LSB first: 8 bits when bit8=1, bits [6:0] when bit8=0.
REQ-025 PARITY SHALL be entered only when parity_en=1.
REQ-026 The parity bit SHALL be the XOR of the transmitted data bits, inverted when odd_n_even=1.
REQ-027 STOP SHALL drive tx=1 for one bit time and pulse tx_done at its end.
REQ-028 At the end of STOP the FSM SHALL go to POP if fifo_empty=0, else to IDLE (back-to-back frames with a 3-clock high gap).
REQ-029 tx SHALL be driven from a register, with no combinational path from any input.
REQ-030 baud_en outside START/DATA/PARITY/STOP SHALL be ignored.

Reset
REQ-031 On aresetn=0 all outputs SHALL take their reset values immediately: tx=1, fifo_rd_n=1, tx_busy=0, tx_done=0.
REQ-032 On aresetn=0 the FSM SHALL go to IDLE and all counters and the shift register SHALL clear to 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no partial pop pending; a byte already popped is lost.
REQ-034 After reset release, the first pop SHALL occur no earlier than the second clock edge.

Structure
REQ-035 The FSM state encoding and the BAUD_DIV default SHALL live in the shared UART package, alongside the receiver's definitions.
REQ-036 The block SHALL have no sub-module; the parity computation SHALL be inline.
REQ-037 Total RTL SHALL be 150-250 lines.

Verification
REQ-038 Single byte 0x55 (8N1, BAUD_DIV=16, baud_en every 4 clocks): fifo_rd_n SHALL be low for exactly 1 clock, and tx SHALL show 0,1,0,1,0,1,0,1,0,1 with each bit lasting 64 clocks, then tx_done pulses once.
REQ-039 Byte 0xA3 (7 data bits, even parity): tx SHALL show start, bits 1,1,0,0,0,1,0, parity 1, stop.
REQ-040 Byte 0x00 (8 data bits, odd parity): the parity bit SHALL be 1.
REQ-041 Three bytes 0x01/0x02/0x03 preloaded: exactly 3 pops; STOP-to-START gap of 3 clocks plus bit alignment; tx_busy stays high throughout; IDLE entered after the third tx_done.
REQ-042 aresetn pulsed low in the middle of data bit 3: tx=1 and fifo_rd_n=1 in the same cycle; after release, the next frame starts cleanly with a start bit.
REQ-043 fifo_empty held at 1 for 1000 clocks: fifo_rd_n SHALL never go low, tx SHALL stay 1, and tx_busy SHALL stay 0; an assertion checks that no pop ever occurs while fifo_empty=1.
